gcd_client: RTL and testbench
=============================

// Module: gcd_client
// PURPOSE
//  Initiator/consumer end of the GCD unit's val/rdy interfaces. Buffers operand
//  pairs from an upstream command stream, issues them to the GCD unit (ops_*),
//  collects each result (res_*), and delivers it downstream tagged with its operands.
//  Sits between the system/test front end and the GCD control+datapath pair.
// PARAMETERS
//  WL     8  operand/result word length (must match the GCD unit)
//  DEPTH  4  operand FIFO entries; power of 2, >=2
//  CNT_W  16 width of completed-operation counter
// PORTS
//  clk       in   1      clock, rising edge
//  rst_b     in   1      reset, asynchronous, active-low
//  cmd_val   in   1      upstream operand pair valid
//  cmd_rdy   out  1      FIFO can accept (= !full)
//  cmd_a     in   WL     operand A
//  cmd_b     in   WL     operand B
//  ops_val   out  1      operand pair to GCD unit valid
//  ops_rdy   in   1      GCD unit ready for operands
//  ops_a     out  WL     operand A to GCD unit (FIFO head)
//  ops_b     out  WL     operand B to GCD unit (FIFO head)
//  res_val   in   1      GCD result valid
//  res_rdy   out  1      client ready for result
//  res_gcd   in   WL     GCD result
//  out_val   out  1      tagged result valid downstream
//  out_rdy   in   1      downstream ready
//  out_a     out  WL     operand A of delivered result
//  out_b     out  WL     operand B of delivered result
//  out_gcd   out  WL     delivered result
//  done_cnt  out  CNT_W  results delivered (out_val&&out_rdy), wraps mod 2^CNT_W
//  busy      out  1      FIFO non-empty or state != ISSUE
// BEHAVIOUR
//  Reset (async, rst_b=0): FIFO empty, state=ISSUE, ops_val=res_rdy=out_val=0,
//   cmd_rdy=1, done_cnt=0, out_a/out_b/out_gcd=0, busy=0. Mid-transaction reset
//   drops all buffered/in-flight pairs; GCD unit shares the reset.
//  Handshake: transfer when val&&rdy at a rising edge; val never depends on rdy;
//   once asserted, val and its data hold until transfer.
//  FIFO: push on cmd_val&&cmd_rdy; pop on ops fire. Push+pop same cycle legal when
//   non-empty (count unchanged). Full: cmd_rdy=0, no bypass. Pointers wrap mod DEPTH.
//  FSM (one pair in flight at a time):
//   ISSUE:   ops_val=!empty; on ops fire latch head into cur_a/cur_b, pop -> WAIT.
//   WAIT:    res_rdy=1; on res fire latch out_gcd<=res_gcd, out_a/b<=cur_a/b -> DELIVER.
//   DELIVER: out_val=1, res_rdy=0, ops_val=0; on out fire done_cnt++ -> ISSUE.
//  Latency: empty FIFO cmd push -> ops_val next cycle; res fire -> out_val next
//   cycle; out fire -> next ops_val next cycle (ISSUE re-entered).
//  ops_val only in ISSUE; res_rdy only in WAIT; res_val outside WAIT is ignored.
//  Operands passed unmodified; zero operands are the GCD unit's concern.
//  done_cnt wraps 2^CNT_W-1 -> 0 without flag.
// STRUCTURE
//  gcd_pkg: client_state_t enum {ISSUE,WAIT,DELIVER}; GCD_WL default localparam.
//  Sub-module gcd_op_fifo (WL*2 wide, DEPTH, push/pop/full/empty, async reset);
//   FSM, cur/out registers and counter stay in gcd_client.
// TESTING
//  Reset: rst_b=0 mid-cycle -> outputs clear immediately; cmd_rdy=1, done_cnt=0.
//  Single op: cmd (48,18), GCD model answers 6 -> ops_a/b=48/18, out (48,18,6), done_cnt=1.
//  Fill: ops_rdy=0, push 4 pairs -> cmd_rdy=0 after 4th, 5th held; release -> FIFO order kept.
//  Backpressure: out_rdy=0 10 cycles -> out_* stable, res_rdy=0, ops_val=0; release -> resume.
//  Push+pop: FIFO count 1, cmd fire and ops fire same edge -> count stays 1, data correct.
//  Reset in WAIT: rst_b=0 -> res_rdy=0, FIFO empty; post-reset cmd (7,5) -> out (7,5,1).
//  Wrap: CNT_W=4, 16 results -> done_cnt 15 -> 0.

Source files
------------

// File: rtl/gcd_pkg.sv
// gcd_pkg: shared word length and client FSM state type for the GCD client slice
package gcd_pkg;
    localparam int GCD_WL = 8;
    typedef enum logic [1:0] {
        ISSUE   = 2'd0,
        WAIT    = 2'd1,
        DELIVER = 2'd2
    } client_state_t;
endpackage

// File: rtl/gcd_client_if.sv
// gcd_client_if: command, operand, result and delivery val/rdy channels of the GCD client
interface gcd_client_if
    import gcd_pkg::*;
#(
    parameter int WL = GCD_WL
) ();
    logic          cmd_val;
    logic          cmd_rdy;
    logic [WL-1:0] cmd_a;
    logic [WL-1:0] cmd_b;
    logic          ops_val;
    logic          ops_rdy;
    logic [WL-1:0] ops_a;
    logic [WL-1:0] ops_b;
    logic          res_val;
    logic          res_rdy;
    logic [WL-1:0] res_gcd;
    logic          out_val;
    logic          out_rdy;
    logic [WL-1:0] out_a;
    logic [WL-1:0] out_b;
    logic [WL-1:0] out_gcd;
    modport master (
        input  cmd_val, cmd_a, cmd_b, ops_rdy, res_val, res_gcd, out_rdy,
        output cmd_rdy, ops_val, ops_a, ops_b, res_rdy, out_val, out_a, out_b, out_gcd
    );
    modport slave (
        output cmd_val, cmd_a, cmd_b, ops_rdy, res_val, res_gcd, out_rdy,
        input  cmd_rdy, ops_val, ops_a, ops_b, res_rdy, out_val, out_a, out_b, out_gcd
    );
endinterface

// File: rtl/gcd_op_fifo.sv
// gcd_op_fifo: operand-pair FIFO, power-of-2 depth, caller never pushes when full or pops when empty
module gcd_op_fifo
    import gcd_pkg::*;
#(
    parameter int W     = 2 * GCD_WL,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_cnt;
    assign o_full  = r_cnt == (AW+1)'(DEPTH);
    assign o_empty = r_cnt == '0;
    assign o_data  = r_mem[r_rd];
    // storage needs no reset: the occupancy count hides stale entries
    always_ff @(posedge clk)
        if (i_push) r_mem[r_wr] <= i_data;
    // pointers wrap naturally at DEPTH; simultaneous push and pop keep the count
    always_ff @(posedge clk or negedge rst_b)
        if (!rst_b) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + AW'(1);
            if (i_pop) r_rd <= r_rd + AW'(1);
            if (i_push && !i_pop) r_cnt <= r_cnt + (AW+1)'(1);
            else if (!i_push && i_pop) r_cnt <= r_cnt - (AW+1)'(1);
        end
endmodule

// File: rtl/gcd_client.sv
// gcd_client: buffers operand pairs, issues them one at a time to the GCD unit and delivers tagged results
module gcd_client
    import gcd_pkg::*;
#(
    parameter int WL    = GCD_WL,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_b,
    gcd_client_if.master      bus,
    output logic [CNT_W-1:0]  done_cnt,
    output logic              busy
);
    client_state_t    r_state;
    logic [WL-1:0]    r_cur_a;
    logic [WL-1:0]    r_cur_b;
    logic [WL-1:0]    r_out_a;
    logic [WL-1:0]    r_out_b;
    logic [WL-1:0]    r_out_gcd;
    logic [CNT_W-1:0] r_done;
    logic [2*WL-1:0]  w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_res_fire;
    logic             w_out_fire;
    assign w_push     = bus.cmd_val && !w_full;
    assign w_pop      = bus.ops_val && bus.ops_rdy;
    assign w_res_fire = bus.res_val && bus.res_rdy;
    assign w_out_fire = bus.out_val && bus.out_rdy;
    gcd_op_fifo #(.W(2 * WL), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_b   (rst_b),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  ({bus.cmd_a, bus.cmd_b}),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );
    assign bus.cmd_rdy          = !w_full;
    assign {bus.ops_a, bus.ops_b} = w_head;
    assign bus.ops_val          = r_state == ISSUE && !w_empty;
    assign bus.res_rdy          = r_state == WAIT;
    assign bus.out_val          = r_state == DELIVER;
    assign bus.out_a            = r_out_a;
    assign bus.out_b            = r_out_b;
    assign bus.out_gcd          = r_out_gcd;
    assign done_cnt             = r_done;
    assign busy                 = !w_empty || r_state != ISSUE;
    // one pair in flight: the three fires are state-exclusive, so at most one branch acts per cycle
    always_ff @(posedge clk or negedge rst_b)
        if (!rst_b) begin
            r_state   <= ISSUE;
            r_cur_a   <= '0;
            r_cur_b   <= '0;
            r_out_a   <= '0;
            r_out_b   <= '0;
            r_out_gcd <= '0;
            r_done    <= '0;
        end else begin
            if (w_pop) begin
                r_cur_a <= w_head[2*WL-1:WL];
                r_cur_b <= w_head[WL-1:0];
                r_state <= WAIT;
            end
            if (w_res_fire) begin
                r_out_gcd <= bus.res_gcd;
                r_out_a   <= r_cur_a;
                r_out_b   <= r_cur_b;
                r_state   <= DELIVER;
            end
            if (w_out_fire) begin
                r_done  <= r_done + CNT_W'(1);
                r_state <= ISSUE;
            end
        end
endmodule

// File: tb/tb_gcd_client.sv
// tb_gcd_client: directed vectors against gcd_client with a behavioural GCD unit on the ops/res side
module tb_gcd_client;
    import gcd_pkg::*;
    localparam int WL    = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    logic             clk = 1'b0;
    logic             rst_b = 1'b0;
    logic [CNT_W-1:0] done_cnt;
    logic             busy;
    logic             model_en;
    int               n_tests = 0;
    int               n_fail = 0;
    int               exp_done = 0;
    gcd_client_if #(.WL(WL)) bus ();
    gcd_client #(.WL(WL), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_b    (rst_b),
        .bus      (bus),
        .done_cnt (done_cnt),
        .busy     (busy)
    );
    always #5 clk = ~clk;
    function automatic logic [WL-1:0] gcd_f(input logic [WL-1:0] a, input logic [WL-1:0] b);
        logic [WL-1:0] t;
        while (b != 0) begin
            t = b;
            b = a % b;
            a = t;
        end
        return a;
    endfunction
    // GCD unit stand-in: answers one cycle after accepting operands, holds until taken
    always @(posedge clk or negedge rst_b)
        if (!rst_b) begin
            bus.res_val <= 1'b0;
            bus.res_gcd <= '0;
        end else if (bus.res_val && bus.res_rdy) begin
            bus.res_val <= 1'b0;
        end else if (model_en && bus.ops_val && bus.ops_rdy) begin
            bus.res_val <= 1'b1;
            bus.res_gcd <= gcd_f(bus.ops_a, bus.ops_b);
        end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic push(input logic [WL-1:0] a, input logic [WL-1:0] b);
        int k = 0;
        bus.cmd_val = 1'b1;
        bus.cmd_a = a;
        bus.cmd_b = b;
        while (!bus.cmd_rdy && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!bus.cmd_rdy) chk("push_timeout", 0, 1);
        else @(posedge clk);
        @(negedge clk);
        bus.cmd_val = 1'b0;
    endtask
    task automatic expect_out(input logic [WL-1:0] a, input logic [WL-1:0] b, input logic [WL-1:0] g, input string tag);
        int k = 0;
        bus.out_rdy = 1'b1;
        while (!bus.out_val && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!bus.out_val) begin
            chk({tag, "_timeout"}, 0, 1);
            bus.out_rdy = 1'b0;
            return;
        end
        chk({tag, "_a"}, 32'(bus.out_a), 32'(a));
        chk({tag, "_b"}, 32'(bus.out_b), 32'(b));
        chk({tag, "_gcd"}, 32'(bus.out_gcd), 32'(g));
        @(posedge clk);
        #1;
        bus.out_rdy = 1'b0;
        exp_done++;
        chk({tag, "_cnt"}, 32'(done_cnt), exp_done % (1 << CNT_W));
    endtask
    task automatic wait_out(input string tag);
        int k = 0;
        while (!bus.out_val && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!bus.out_val) chk({tag, "_timeout"}, 0, 1);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        bus.cmd_val = 1'b0;
        bus.cmd_a = '0;
        bus.cmd_b = '0;
        bus.ops_rdy = 1'b0;
        bus.out_rdy = 1'b0;
        model_en = 1'b1;
        #3;
        chk("rst_cmd_rdy", 32'(bus.cmd_rdy), 1);
        chk("rst_ops_val", 32'(bus.ops_val), 0);
        chk("rst_res_rdy", 32'(bus.res_rdy), 0);
        chk("rst_out_val", 32'(bus.out_val), 0);
        chk("rst_out_abg", {8'd0, bus.out_a, bus.out_b, bus.out_gcd}, 0);
        chk("rst_done", 32'(done_cnt), 0);
        chk("rst_busy", 32'(busy), 0);
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        bus.ops_rdy = 1'b1;
        push(48, 18);
        chk("single_ops_val", 32'(bus.ops_val), 1);
        chk("single_ops_a", 32'(bus.ops_a), 48);
        chk("single_ops_b", 32'(bus.ops_b), 18);
        expect_out(48, 18, 6, "single");
        @(negedge clk);
        chk("single_busy", 32'(busy), 0);
        bus.ops_rdy = 1'b0;
        push(12, 8);
        push(100, 75);
        push(9, 27);
        push(17, 34);
        chk("fill_cmd_rdy", 32'(bus.cmd_rdy), 0);
        chk("fill_head_a", 32'(bus.ops_a), 12);
        bus.cmd_val = 1'b1;
        bus.cmd_a = 21;
        bus.cmd_b = 14;
        repeat (3) @(negedge clk);
        chk("fill_held_rdy", 32'(bus.cmd_rdy), 0);
        chk("fill_held_head", 32'(bus.ops_b), 8);
        bus.ops_rdy = 1'b1;
        push(21, 14);
        expect_out(12, 8, 4, "fill0");
        expect_out(100, 75, 25, "fill1");
        expect_out(9, 27, 9, "fill2");
        expect_out(17, 34, 17, "fill3");
        expect_out(21, 14, 7, "fill4");
        @(negedge clk);
        chk("fill_busy", 32'(busy), 0);
        push(36, 24);
        push(15, 10);
        wait_out("bp");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold_abg", {8'd0, bus.out_a, bus.out_b, bus.out_gcd}, {8'd0, 8'd36, 8'd24, 8'd12});
            chk("bp_res_rdy", 32'(bus.res_rdy), 0);
            chk("bp_ops_val", 32'(bus.ops_val), 0);
        end
        expect_out(36, 24, 12, "bp1");
        expect_out(15, 10, 5, "bp2");
        @(negedge clk);
        bus.ops_rdy = 1'b0;
        push(40, 16);
        bus.cmd_val = 1'b1;
        bus.cmd_a = 50;
        bus.cmd_b = 20;
        bus.ops_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_val = 1'b0;
        chk("pp_ops_a", 32'(bus.ops_a), 50);
        chk("pp_ops_b", 32'(bus.ops_b), 20);
        chk("pp_res_rdy", 32'(bus.res_rdy), 1);
        chk("pp_cmd_rdy", 32'(bus.cmd_rdy), 1);
        expect_out(40, 16, 8, "pp1");
        expect_out(50, 20, 10, "pp2");
        @(negedge clk);
        chk("pp_busy", 32'(busy), 0);
        model_en = 1'b0;
        push(77, 11);
        push(3, 3);
        chk("rw_res_rdy_pre", 32'(bus.res_rdy), 1);
        #2;
        rst_b = 1'b0;
        #1;
        exp_done = 0;
        chk("rw_res_rdy", 32'(bus.res_rdy), 0);
        chk("rw_busy", 32'(busy), 0);
        chk("rw_cmd_rdy", 32'(bus.cmd_rdy), 1);
        chk("rw_ops_val", 32'(bus.ops_val), 0);
        chk("rw_done", 32'(done_cnt), 0);
        @(negedge clk);
        rst_b = 1'b1;
        model_en = 1'b1;
        @(negedge clk);
        push(7, 5);
        expect_out(7, 5, 1, "post_rst");
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            push(8'(i * 6), 8'(i * 4));
            expect_out(8'(i * 6), 8'(i * 4), 8'(i * 2), "wrap");
            if (i == 14) chk("wrap_max", 32'(done_cnt), 15);
        end
        chk("wrap_zero", 32'(done_cnt), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
